// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB2APB bridge: APB FSM encoding and request-entry sizing helpers.
package ahb_apb_pkg;

    localparam int unsigned APB_STATE_W = 2;

    typedef enum logic [APB_STATE_W-1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam apb_state_e APB_RESET_STATE = APB_IDLE;

    // Queued request layout, MSB first: {write, addr, wdata, sel}
    function automatic int unsigned req_entry_width(input int unsigned addr_w,
                                                    input int unsigned data_w,
                                                    input int unsigned nslv);
        return 1 + addr_w + data_w + nslv;
    endfunction

    // Timeout counter must hold the value TIMEOUT itself; keep one bit when disabled
    function automatic int unsigned tmo_cnt_width(input int unsigned tmo);
        return (tmo == 0) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module apb_req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             afull,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        afull_d  = (count_d == PW'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: empty_q guards every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign afull   = afull_q;
    assign empty   = empty_q;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 master controller: posted-write request queue, SETUP/ACCESS sequencing with
// wait states, slave-error reporting and a hung-transfer timeout.
module apb_master_ctrl
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [NSLV-1:0]   tempselx,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata,
    output logic              rd_done,
    output logic              Hresp,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr
);
    localparam int unsigned      ENTRY_W   = req_entry_width(ADDR_W, DATA_W, NSLV);
    localparam int unsigned      CNT_W     = tmo_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    apb_state_e        state_q, state_d;
    logic [NSLV-1:0]   pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              rd_done_q, rd_done_d;
    logic              hresp_q, hresp_d;
    logic              rd_pend_q, rd_pend_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic [NSLV-1:0]    head_sel;
    logic               fifo_full, fifo_afull, fifo_empty;
    logic               accept, pop, timeout_hit, xfer_done, full_next;

    assign accept     = valid && ready_q;
    assign push_entry = {Hwrite, Haddr, Hwdata, tempselx};
    assign {head_write, head_addr, head_wdata, head_sel} = head_entry;

    apb_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (Hclk),
        .rst_n   (Hresetn),
        .push    (accept),
        .wdata   (push_entry),
        .pop     (pop),
        .rdata_c (head_entry),
        .full    (fifo_full),
        .afull   (fifo_afull),
        .empty   (fifo_empty)
    );

    // Transfer completion and queue pop for this cycle
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (state_q == APB_ACCESS) && !Pready
                      && (tmo_cnt_q == TMO_LIMIT);
        xfer_done   = (state_q == APB_ACCESS) && (Pready || timeout_hit);
        pop         = ((state_q == APB_IDLE) || xfer_done) && !fifo_empty;
        full_next   = !pop && (fifo_full || (fifo_afull && accept));
    end

    always_comb begin
        state_d   = state_q;
        pselx_d   = pselx_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hrdata_d  = hrdata_q;
        rd_done_d = 1'b0;
        hresp_d   = 1'b0;
        rd_pend_d = rd_pend_q;
        tmo_cnt_d = tmo_cnt_q;

        unique case (state_q)
            APB_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = APB_SETUP;
                    pselx_d  = head_sel;
                    pwrite_d = head_write;
                    paddr_d  = head_addr;
                    pwdata_d = head_wdata;
                end
            end
            APB_SETUP: begin
                state_d   = APB_ACCESS;
                penable_d = 1'b1;
                tmo_cnt_d = '0;
            end
            APB_ACCESS: begin
                if (xfer_done) begin
                    penable_d = 1'b0;
                    hresp_d   = timeout_hit || Pslverr;
                    if (!pwrite_q) begin
                        rd_done_d = 1'b1;
                        rd_pend_d = 1'b0;
                        hrdata_d  = timeout_hit ? '0 : Prdata;
                    end
                    // Back-to-back: load the next entry straight into SETUP
                    if (!fifo_empty) begin
                        state_d  = APB_SETUP;
                        pselx_d  = head_sel;
                        pwrite_d = head_write;
                        paddr_d  = head_addr;
                        pwdata_d = head_wdata;
                    end else begin
                        state_d  = APB_IDLE;
                        pselx_d  = '0;
                        pwrite_d = 1'b0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = APB_IDLE;
                pselx_d   = '0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
            end
        endcase

        if (accept && !Hwrite) begin
            rd_pend_d = 1'b1;
        end
        ready_d = !full_next && !rd_pend_d;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= APB_RESET_STATE;
            pselx_q   <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
            rd_done_q <= 1'b0;
            hresp_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            ready_q   <= 1'b1;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hrdata_q  <= hrdata_d;
            rd_done_q <= rd_done_d;
            hresp_q   <= hresp_d;
            rd_pend_q <= rd_pend_d;
            ready_q   <= ready_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign Hreadyout = ready_q;
    assign Hrdata    = hrdata_q;
    assign rd_done   = rd_done_q;
    assign Hresp     = hresp_q;
    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;

endmodule
